// File: rtl/psum_pkg.sv
// psum_pkg: shared FSM states and default sizes for the partial-sum accumulator
package psum_pkg;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  localparam int PSUM_BW_DEF = 16;
  localparam int NUM_KIJ_DEF = 9;
endpackage

// File: rtl/psum_relu.sv
// psum_relu: combinational signed ReLU, negative values clamp to zero
module psum_relu #(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] d,
  output logic [psum_bw-1:0] q
);
  assign q = d[psum_bw-1] ? '0 : d;
endmodule

// File: rtl/psum_acc_seq.sv
// psum_acc_seq: accumulates num_kij partial sums per output pixel, optional ReLU
// The ReLU stage is built only when PSUM_ACC_RELU_EN is defined.
module psum_acc_seq
  import psum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int num_kij = NUM_KIJ_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [psum_bw-1:0] in,
  output logic               in_ready,
  input  logic               relu_en,
  output logic               out_valid,
  output logic [psum_bw-1:0] out,
  input  logic               out_ready,
  output logic [15:0]        pix_cnt
);
  state_t state;
  logic [psum_bw-1:0] acc, sum, res;
  logic [7:0] kcnt;
  logic beat, last;
  assign in_ready = rst && state != HOLD;
  assign beat = in_valid && in_ready;
  assign sum = state == IDLE ? in : acc + in;
  assign last = state == ACC && kcnt == 8'(num_kij - 1);
`ifdef PSUM_ACC_RELU_EN
  logic [psum_bw-1:0] rel;
  psum_relu #(.psum_bw(psum_bw)) u_relu (.d(sum), .q(rel));
  assign res = relu_en ? rel : sum;
`else
  logic unused_relu;
  assign unused_relu = relu_en;
  assign res = sum;
`endif
  // relu_en is captured with the last beat, so out already carries the pixel's ReLU choice
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      kcnt      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      pix_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (beat) begin
          acc   <= sum;
          kcnt  <= 8'd1;
          state <= ACC;
        end
        ACC: if (beat) begin
          acc  <= sum;
          kcnt <= kcnt + 8'd1;
          if (last) begin
            state     <= HOLD;
            out       <= res;
            out_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          pix_cnt   <= pix_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_acc_seq.sv
// tb_psum_acc_seq: directed self-checking bench for psum_acc_seq (default parameters)
module tb_psum_acc_seq;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, relu_en = 1'b0, out_ready = 1'b0;
  logic [15:0] in = '0;
  logic in_ready, out_valid;
  logic [15:0] out, pix_cnt;
  int n_cmp = 0, n_bad = 0;
  int exp_pix = 0;
  always #5 clk = ~clk;
  psum_acc_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .in_ready(in_ready),
    .relu_en(relu_en), .out_valid(out_valid), .out(out), .out_ready(out_ready),
    .pix_cnt(pix_cnt)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input int v[9], input bit r, input int gap_at);
    for (int i = 0; i < 9; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        in = 16'h5555;
        tick();
      end
      chk("in_ready_beat", int'(in_ready), 1);
      in_valid = 1'b1;
      in = 16'(v[i]);
      relu_en = r;
      tick();
    end
    in_valid = 1'b0;
    relu_en = 1'b0;
  endtask
  task automatic done(input string tag, input int exp);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_out"}, int'($signed(out)), exp);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
  endtask
  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_pix++;
    chk({tag, "_valid_drop"}, int'(out_valid), 0);
    chk({tag, "_pix_cnt"}, int'(pix_cnt), exp_pix);
    chk({tag, "_idle_ready"}, int'(in_ready), 1);
  endtask
  initial begin
    int ramp[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int neg[9]  = '{-10, -10, -10, -10, -10, -10, -10, -10, -10};
    int wrp[9]  = '{32767, 1, 0, 0, 0, 0, 0, 0, 0};
    int ones[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int twos[9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    tick();
    tick();
    chk("rst_out", int'(out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_pix", int'(pix_cnt), 0);
    rst = 1'b1;
    tick();
    // out_ready held high through accumulation must have no effect
    out_ready = 1'b1;
    feed(ramp, 1'b0, 9);
    out_ready = 1'b0;
    done("ramp", 45);
    chk("ramp_pix_before", int'(pix_cnt), 0);
    drain("ramp");
`ifdef PSUM_ACC_RELU_EN
    feed(neg, 1'b1, 4);
    done("relu", 0);
`else
    feed(neg, 1'b1, 4);
    done("relu", -90);
`endif
    drain("relu");
    feed(wrp, 1'b0, 9);
    done("wrap", -32768);
    drain("wrap");
    feed(ramp, 1'b0, 9);
    in_valid = 1'b1;
    in = 16'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      done("hold", 45);
    end
    in_valid = 1'b0;
    drain("hold");
    feed(ones, 1'b0, 9);
    done("after_hold", 9);
    drain("after_hold");
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in = 16'd7;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    exp_pix = 0;
    chk("midrst_pix", int'(pix_cnt), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_valid", int'(out_valid), 0);
    rst = 1'b1;
    tick();
    feed(twos, 1'b0, 9);
    done("midrst", 18);
    drain("midrst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/psum_acc_seq.md
PSUM_ACC_SEQ -- requirements
Module: psum_acc_seq

Interface
REQ-001 The block SHALL have parameter psum_bw, default 16, giving the partial-sum width in bits.
REQ-002 The block SHALL have parameter num_kij, default 9, giving the partial sums accumulated per output pixel (2..255).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  the upstream partial sum is present.
REQ-006 The block SHALL have port in  input  psum_bw  the signed partial sum from the array column.
REQ-007 The block SHALL have port in_ready  output  1  the block accepts in this cycle.
REQ-008 The block SHALL have port relu_en  input  1  apply ReLU to the finished pixel.
REQ-009 The block SHALL have port out_valid  output  1  the finished pixel is on out.
REQ-010 The block SHALL have port out  output  psum_bw  the signed finished pixel.
REQ-011 The block SHALL have port out_ready  input  1  downstream takes out this cycle.
REQ-012 The block SHALL have port pix_cnt  output  16  the number of pixels delivered since reset, wrapping.

Function
REQ-013 A beat SHALL transfer on a rising edge with in_valid && in_ready; out SHALL transfer with out_valid && out_ready.
REQ-014 The FSM SHALL have states IDLE, ACC and HOLD, and SHALL reset to IDLE.
REQ-015 In IDLE: in_ready=1; on a beat, acc<=in, kcnt<=1, next state ACC.
REQ-016 In ACC: in_ready=1; on a beat, acc<=acc+in, kcnt<=kcnt+1.
REQ-017 When the beat with kcnt==num_kij-1 transfers, the next state SHALL be HOLD.
REQ-018 In HOLD: in_ready=0, out_valid=1, and out SHALL hold stable until transfer.
REQ-019 In HOLD, out_ready=1 SHALL return the FSM to IDLE and increment pix_cnt.
REQ-020 Latency SHALL be 1 cycle: out_valid rises on the cycle after the last beat is accepted.
REQ-021 Full-rate operation SHALL accept one pixel per num_kij+1 cycles.
REQ-022 Addition SHALL be psum_bw-bit two's-complement with wrap-around and no saturation.
REQ-023 relu_en SHALL be sampled when the last beat of a pixel transfers and held for that pixel; with ReLU applied, negative acc SHALL give out=0.
REQ-024 With in_valid=0 in ACC, acc and kcnt SHALL hold, with no timeout.
REQ-025 out_ready asserted outside HOLD SHALL have no effect.

Reset
REQ-026 When rst=0 at a rising edge, the block SHALL set state=IDLE, acc=0, kcnt=0, out=0, out_valid=0 and pix_cnt=0, and SHALL hold in_ready=0 while in reset.
REQ-027 A reset during ACC or HOLD SHALL discard the partial pixel; the first beat after reset release SHALL start a new pixel.

Configuration
REQ-028 With macro PSUM_ACC_RELU_EN defined, the ReLU stage SHALL be built and behave per REQ-023.
REQ-029 With PSUM_ACC_RELU_EN undefined, relu_en SHALL be ignored and out SHALL equal acc unmodified; the ports SHALL be unchanged.

Structure
REQ-030 Package psum_pkg SHALL hold the state enum (IDLE/ACC/HOLD), PSUM_BW_DEF=16 and NUM_KIJ_DEF=9.
REQ-031 One sub-module, psum_relu, SHALL be the combinational signed ReLU, instantiated only under PSUM_ACC_RELU_EN.
REQ-032 kcnt SHALL be 8 bits wide.

Verification
REQ-033 The bench SHALL cover: rst=0 for 2 cycles -> out=0, out_valid=0, in_ready=0, pix_cnt=0.
REQ-034 The bench SHALL cover: num_kij=9, back-to-back ins of 1..9 with relu_en=0 and out_ready=1 -> out=45 one cycle after the 9th beat, then pix_cnt=1.
REQ-035 The bench SHALL cover: ins of -10 ×9 with relu_en=1 and the macro defined -> out=0; with the macro undefined -> out=-90.
REQ-036 The bench SHALL cover: psum_bw=16, ins 32767 then 1 and then seven 0s -> out=-32768 (wrap).
REQ-037 The bench SHALL cover: out_ready held 0 for 5 cycles in HOLD -> out stable, in_ready=0, no beat accepted; release -> IDLE next cycle.
REQ-038 The bench SHALL cover: rst=0 after 4 beats, then 9 ins of 2 -> out=18 with no contribution from the earlier beats.
